// File: rtl/frac_pkg.sv
// Shared constants, register map, FSM state type and saturation helper for
// the Mandelbrot escape-time engine.
package frac_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned FRAC_W = 28;
  localparam int unsigned ITER_W = 16;
  localparam logic [DATA_W-1:0] ID_VALUE = 32'h4652_4143;

  // Full product, escape magnitude (one bit of headroom) and pre-saturation sum widths
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned MAG_W  = PROD_W + 1;
  localparam int unsigned SUM_W  = DATA_W + 2;

  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 8'h01;
  localparam logic [ADDR_W-1:0] ADDR_C_RE     = 8'h02;
  localparam logic [ADDR_W-1:0] ADDR_C_IM     = 8'h03;
  localparam logic [ADDR_W-1:0] ADDR_MAX_ITER = 8'h04;
  localparam logic [ADDR_W-1:0] ADDR_ITER_CNT = 8'h05;
  localparam logic [ADDR_W-1:0] ADDR_ID       = 8'h06;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_ABORT    = 1;
  localparam int unsigned CTRL_DONE_CLR = 2;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_DONE    = 1;
  localparam int unsigned ST_ESCAPED = 2;

  localparam logic [ITER_W-1:0] MAX_ITER_RST = 16'h0100;

  localparam logic [DATA_W-1:0] ONE_Q  = 32'h1000_0000;
  localparam logic [DATA_W-1:0] FOUR_Q = 32'h4000_0000;
  // 4.0 at the scale of a raw square (2*FRAC_W fractional bits)
  localparam logic signed [MAG_W-1:0] FOUR_MAG =
    {{(MAG_W - 2*FRAC_W - 3){1'b0}}, 3'b100, {(2*FRAC_W){1'b0}}};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Clamp a widened sum to the signed DATA_W range
  function automatic logic [DATA_W-1:0] sat_q(input logic [SUM_W-1:0] v);
    logic [SUM_W-DATA_W:0] top;
    top = v[SUM_W-1:DATA_W-1];
    if ((top == '0) || (top == '1)) return v[DATA_W-1:0];
    else if (v[SUM_W-1])            return {1'b1, {(DATA_W-1){1'b0}}};
    else                            return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/frac_if.sv
// Peripheral bus bundle. master = CPU side, slave = frac_unit side.
interface frac_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              pi_blk_sel;
  logic [ADDR_W-1:0] pi_addr;
  logic              pi_wr_en;
  logic              pi_rd_en;
  logic [DATA_W-1:0] pi_wr_data;
  logic [DATA_W-1:0] pi_rd_data;

  modport master (
    output pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data,
    input  pi_rd_data
  );

  modport slave (
    input  pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data,
    output pi_rd_data
  );
endinterface

// File: rtl/frac_iter_dp.sv
// One Mandelbrot iteration, purely combinational.
//   i_zr/i_zi     current z (Q4.28)
//   i_c_re/i_c_im point c (Q4.28)
//   o_zr_next_c/o_zi_next_c  saturated z^2 + c
//   o_escaped_c   |z|^2 > 4.0, judged on the unrounded squares
module frac_iter_dp
  import frac_pkg::*;
(
  input  logic signed [DATA_W-1:0] i_zr,
  input  logic signed [DATA_W-1:0] i_zi,
  input  logic signed [DATA_W-1:0] i_c_re,
  input  logic signed [DATA_W-1:0] i_c_im,
  output logic        [DATA_W-1:0] o_zr_next_c,
  output logic        [DATA_W-1:0] o_zi_next_c,
  output logic                     o_escaped_c
);

  logic signed [PROD_W-1:0] w_zr_x, w_zi_x;
  logic signed [PROD_W-1:0] w_zr2, w_zi2, w_zrzi;
  logic signed [DATA_W-1:0] w_zr2_s, w_zi2_s, w_zrzi_s;
  logic signed [MAG_W-1:0]  w_mag;
  logic signed [SUM_W-1:0]  w_re_sum, w_im_sum;

  // Sign-extend before multiplying so the products are exact
  assign w_zr_x = PROD_W'(i_zr);
  assign w_zi_x = PROD_W'(i_zi);
  assign w_zr2  = w_zr_x * w_zr_x;
  assign w_zi2  = w_zi_x * w_zi_x;
  assign w_zrzi = w_zr_x * w_zi_x;

  // Back to Q4.28: product bits [FRAC_W+DATA_W-1:FRAC_W]
  assign w_zr2_s  = DATA_W'(w_zr2  >>> FRAC_W);
  assign w_zi2_s  = DATA_W'(w_zi2  >>> FRAC_W);
  assign w_zrzi_s = DATA_W'(w_zrzi >>> FRAC_W);

  assign w_mag       = MAG_W'(w_zr2) + MAG_W'(w_zi2);
  assign o_escaped_c = (w_mag > FOUR_MAG);

  assign w_re_sum = SUM_W'(w_zr2_s) - SUM_W'(w_zi2_s) + SUM_W'(i_c_re);
  assign w_im_sum = (SUM_W'(w_zrzi_s) <<< 1) + SUM_W'(i_c_im);

  assign o_zr_next_c = sat_q(w_re_sum);
  assign o_zi_next_c = sat_q(w_im_sum);

endmodule

// File: rtl/frac_unit.sv
// Memory-mapped Mandelbrot escape-time engine: register file, IDLE/RUN FSM
// and iteration counter around the frac_iter_dp datapath.
//   clk  system clock
//   rst  asynchronous reset, active-low
//   bus  peripheral bus slave (pi_*), read data registered
module frac_unit
  import frac_pkg::*;
(
  input  logic clk,
  input  logic rst,
  frac_if.slave bus
);

  // Programmable registers
  logic [DATA_W-1:0] r_c_re, r_c_im;
  logic [ITER_W-1:0] r_max_iter;
  logic [ITER_W-1:0] r_iter_cnt;
  logic              r_done, r_escaped;
  logic [DATA_W-1:0] r_rd_data;

  // Working copies used by the current run
  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_zr, r_zi, r_wc_re, r_wc_im;
  logic [ITER_W-1:0] r_k, r_wmax;

  logic              w_wr, w_rd, w_ctrl_wr;
  logic              w_load, w_step, w_finish;
  logic [DATA_W-1:0] w_zr_next, w_zi_next, w_rd_mux, w_status;
  logic              w_escaped;

  assign w_wr      = bus.pi_blk_sel & bus.pi_wr_en;
  assign w_rd      = bus.pi_blk_sel & bus.pi_rd_en;
  assign w_ctrl_wr = w_wr & (bus.pi_addr == ADDR_CTRL);

  frac_iter_dp u_dp (
    .i_zr        (r_zr),
    .i_zi        (r_zi),
    .i_c_re      (r_wc_re),
    .i_c_im      (r_wc_im),
    .o_zr_next_c (w_zr_next),
    .o_zi_next_c (w_zi_next),
    .o_escaped_c (w_escaped)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next state and datapath strobes; escape is checked before the limit
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ctrl_wr && bus.pi_wr_data[CTRL_START]) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_ctrl_wr && bus.pi_wr_data[CTRL_ABORT]) begin
          w_state_nxt = IDLE;
        end else if (w_escaped || (r_k == r_wmax)) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_step = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Iteration state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_zr    <= '0;
      r_zi    <= '0;
      r_k     <= '0;
      r_wc_re <= '0;
      r_wc_im <= '0;
      r_wmax  <= '0;
    end else if (w_load) begin
      r_zr    <= '0;
      r_zi    <= '0;
      r_k     <= '0;
      r_wc_re <= r_c_re;
      r_wc_im <= r_c_im;
      r_wmax  <= r_max_iter;
    end else if (w_step) begin
      r_zr <= w_zr_next;
      r_zi <= w_zi_next;
      r_k  <= r_k + ITER_W'(1);
    end
  end

  // Result and status; completion beats a same-cycle DONE_CLR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done     <= 1'b0;
      r_escaped  <= 1'b0;
      r_iter_cnt <= '0;
    end else if (w_finish) begin
      r_done     <= 1'b1;
      r_escaped  <= w_escaped;
      r_iter_cnt <= r_k;
    end else if (w_load) begin
      r_done    <= 1'b0;
      r_escaped <= 1'b0;
    end else if (w_ctrl_wr && bus.pi_wr_data[CTRL_DONE_CLR]) begin
      r_done <= 1'b0;
    end
  end

  // Configuration registers; mid-run writes only matter at the next START
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c_re     <= '0;
      r_c_im     <= '0;
      r_max_iter <= MAX_ITER_RST;
    end else if (w_wr) begin
      case (bus.pi_addr)
        ADDR_C_RE:     r_c_re     <= bus.pi_wr_data;
        ADDR_C_IM:     r_c_im     <= bus.pi_wr_data;
        ADDR_MAX_ITER: r_max_iter <= bus.pi_wr_data[ITER_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_status             = '0;
    w_status[ST_BUSY]    = (r_state == RUN);
    w_status[ST_DONE]    = r_done;
    w_status[ST_ESCAPED] = r_escaped;
  end

  // Read mux; CTRL and unmapped addresses return 0
  always_comb begin
    w_rd_mux = '0;
    case (bus.pi_addr)
      ADDR_STATUS:   w_rd_mux = w_status;
      ADDR_C_RE:     w_rd_mux = r_c_re;
      ADDR_C_IM:     w_rd_mux = r_c_im;
      ADDR_MAX_ITER: w_rd_mux = DATA_W'(r_max_iter);
      ADDR_ITER_CNT: w_rd_mux = DATA_W'(r_iter_cnt);
      ADDR_ID:       w_rd_mux = ID_VALUE;
      default:       w_rd_mux = '0;
    endcase
  end

  // Registered read data, zero when not reading
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_rd_data <= '0;
    else if (w_rd) r_rd_data <= w_rd_mux;
    else           r_rd_data <= '0;
  end

  assign bus.pi_rd_data = r_rd_data;

endmodule

// File: tb/tb_frac_unit.sv
// Directed bench for frac_unit: vector table of points plus hand sequences
// for abort, restart-ignore, mid-run reset, DONE_CLR and bus corner cases.
module tb_frac_unit;

  localparam logic [7:0] A_CTRL = 8'h00, A_STATUS = 8'h01, A_C_RE = 8'h02,
                         A_C_IM = 8'h03, A_MAX = 8'h04, A_CNT = 8'h05,
                         A_ID = 8'h06, A_UNMAP = 8'h3F;
  localparam int POLL_LIMIT = 300;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;

  frac_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  frac_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] c_re;
    logic [31:0] c_im;
    logic [15:0] max_iter;
    logic [15:0] cnt;
    logic        esc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus.pi_blk_sel = 1'b1; bus.pi_wr_en = 1'b1; bus.pi_addr = a; bus.pi_wr_data = d;
    @(negedge clk);
    bus.pi_blk_sel = 1'b0; bus.pi_wr_en = 1'b0; bus.pi_wr_data = '0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bus.pi_blk_sel = 1'b1; bus.pi_rd_en = 1'b1; bus.pi_addr = a;
    @(negedge clk);
    d = bus.pi_rd_data;
    bus.pi_blk_sel = 1'b0; bus.pi_rd_en = 1'b0;
  endtask

  // Poll STATUS every cycle until BUSY drops; returns last status and cycle stamp
  task automatic poll_idle(output logic [31:0] st, output int end_cyc);
    bit ok;
    ok = 1'b0;
    st = '0;
    bus.pi_blk_sel = 1'b1; bus.pi_rd_en = 1'b1; bus.pi_addr = A_STATUS;
    for (int i = 0; i < POLL_LIMIT; i++) begin
      @(negedge clk);
      st = bus.pi_rd_data;
      if (!st[0]) begin ok = 1'b1; break; end
    end
    end_cyc = cyc;
    bus.pi_blk_sel = 1'b0; bus.pi_rd_en = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL poll_timeout: BUSY still 1 after %0d cycles", POLL_LIMIT);
    end
  endtask

  initial begin
    logic [31:0] rd, st, exp_st;
    int          s, e;

    n_cmp = 0; n_err = 0; cyc = 0;
    bus.pi_blk_sel = 1'b0; bus.pi_addr = '0; bus.pi_wr_en = 1'b0;
    bus.pi_rd_en = 1'b0; bus.pi_wr_data = '0;

    //         c_re           c_im           max      cnt      esc
    vecs[0] = '{32'h2000_0000, 32'h0000_0000, 16'h0100, 16'd2,  1'b1}; // 0,2,6
    vecs[1] = '{32'h1000_0000, 32'h0000_0000, 16'h0100, 16'd3,  1'b1}; // 0,1,2,5
    vecs[2] = '{32'hE000_0000, 32'h0000_0000, 16'd20,   16'd20, 1'b0}; // |z|^2 stays 4
    vecs[3] = '{32'h0000_0000, 32'h2000_0000, 16'h0100, 16'd2,  1'b1}; // 0,2i,-4+2i
    vecs[4] = '{32'hF000_0000, 32'h0000_0000, 16'd10,   16'd10, 1'b0}; // 0,-1,0,-1..
    vecs[5] = '{32'h3000_0000, 32'h0000_0000, 16'h0100, 16'd1,  1'b1}; // 0,3
    vecs[6] = '{32'h1000_0000, 32'h0000_0000, 16'd3,    16'd3,  1'b1}; // escape beats limit
    vecs[7] = '{32'h1000_0000, 32'h0000_0000, 16'd2,    16'd2,  1'b0}; // mag=4 at limit
    vecs[8] = '{32'h0000_0000, 32'h0000_0000, 16'd0,    16'd0,  1'b0}; // single RUN cycle

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_data", bus.pi_rd_data, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    bus_read(A_ID, rd);       check("reset_id", rd, 32'h4652_4143);
    bus_read(A_MAX, rd);      check("reset_max_iter", rd, 32'h0000_0100);
    bus_read(A_STATUS, rd);   check("reset_status", rd, 32'h0);
    bus_read(A_CNT, rd);      check("reset_iter_cnt", rd, 32'h0);
    bus_read(A_C_RE, rd);     check("reset_c_re", rd, 32'h0);
    @(negedge clk);
    check("rd_data_idle", bus.pi_rd_data, 32'h0);

    // Vector table: a run of N iterations is N+1 RUN cycles, and the first
    // idle STATUS sample lands N+2 edges after the START edge
    for (int v = 0; v < 9; v++) begin
      bus_write(A_C_RE, vecs[v].c_re);
      bus_write(A_C_IM, vecs[v].c_im);
      bus_write(A_MAX, 32'(vecs[v].max_iter));
      bus_write(A_CTRL, 32'h1);
      s = cyc;
      poll_idle(st, e);
      exp_st = {29'd0, vecs[v].esc, 1'b1, 1'b0};
      check($sformatf("v%0d_busy_span", v), 32'(e - s), 32'(vecs[v].cnt) + 32'd2);
      check($sformatf("v%0d_status", v), st, exp_st);
      bus_read(A_CNT, rd);
      check($sformatf("v%0d_iter_cnt", v), rd, 32'(vecs[v].cnt));
    end

    // START and C_RE writes during a run: run continues unchanged
    bus_write(A_C_RE, 32'h0);
    bus_write(A_C_IM, 32'h0);
    bus_write(A_MAX, 32'd20);
    bus_write(A_CTRL, 32'h1);
    s = cyc;
    repeat (5) @(negedge clk);
    bus_write(A_C_RE, 32'h2000_0000);
    bus_write(A_CTRL, 32'h1);
    poll_idle(st, e);
    check("restart_busy_span", 32'(e - s), 32'd22);
    check("restart_status", st, 32'b010);
    bus_read(A_CNT, rd);      check("restart_iter_cnt", rd, 32'd20);
    bus_read(A_C_RE, rd);     check("midrun_c_re_stored", rd, 32'h2000_0000);

    // ABORT after 10 cycles: idle, DONE 0, ITER_CNT keeps 20
    bus_write(A_C_RE, 32'h0);
    bus_write(A_MAX, 32'h1000);
    bus_write(A_CTRL, 32'h1);
    repeat (10) @(negedge clk);
    bus_read(A_STATUS, rd);   check("pre_abort_busy", rd, 32'b001);
    bus_write(A_CTRL, 32'h2);
    bus_read(A_STATUS, rd);   check("abort_status", rd, 32'h0);
    bus_read(A_CNT, rd);      check("abort_iter_cnt", rd, 32'd20);
    bus_write(A_CTRL, 32'h2);
    bus_read(A_STATUS, rd);   check("abort_idle_noop", rd, 32'h0);

    // Reset in the middle of a run
    bus_write(A_C_RE, 32'h1234_5678);
    bus_write(A_C_IM, 32'h0765_4321);
    bus_write(A_MAX, 32'h1000);
    bus_write(A_CTRL, 32'h1);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rd_data", bus.pi_rd_data, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    bus_read(A_STATUS, rd);   check("midrst_status", rd, 32'h0);
    bus_read(A_C_RE, rd);     check("midrst_c_re", rd, 32'h0);
    bus_read(A_C_IM, rd);     check("midrst_c_im", rd, 32'h0);
    bus_read(A_MAX, rd);      check("midrst_max_iter", rd, 32'h0000_0100);
    bus_read(A_CNT, rd);      check("midrst_iter_cnt", rd, 32'h0);

    // MAX_ITER = 0, DONE_CLR, unmapped and CTRL reads
    bus_write(A_MAX, 32'd0);
    bus_write(A_CTRL, 32'h1);
    s = cyc;
    poll_idle(st, e);
    check("max0_busy_span", 32'(e - s), 32'd2);
    check("max0_status", st, 32'b010);
    bus_read(A_CNT, rd);      check("max0_iter_cnt", rd, 32'h0);
    bus_write(A_CTRL, 32'h4);
    bus_read(A_STATUS, rd);   check("done_clr_status", rd, 32'h0);
    bus_read(A_UNMAP, rd);    check("unmapped_read", rd, 32'h0);
    bus_write(A_UNMAP, 32'hFFFF_FFFF);
    bus_read(A_UNMAP, rd);    check("unmapped_write_ignored", rd, 32'h0);
    bus_read(A_CTRL, rd);     check("ctrl_reads_zero", rd, 32'h0);

    // DONE_CLR on the completing cycle: completion wins
    bus_write(A_CTRL, 32'h1);
    bus_write(A_CTRL, 32'h4);
    bus_read(A_STATUS, rd);   check("done_clr_vs_finish", rd, 32'b010);

    // Simultaneous read and write of one register returns the old value
    bus.pi_blk_sel = 1'b1; bus.pi_rd_en = 1'b1; bus.pi_wr_en = 1'b1;
    bus.pi_addr = A_C_IM; bus.pi_wr_data = 32'hCAFE_0001;
    @(negedge clk);
    rd = bus.pi_rd_data;
    bus.pi_blk_sel = 1'b0; bus.pi_rd_en = 1'b0; bus.pi_wr_en = 1'b0;
    check("rdwr_old_value", rd, 32'h0);
    bus_read(A_C_IM, rd);     check("rdwr_new_value", rd, 32'hCAFE_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
